// File: rtl/mips_pkg.sv
// Shared fetch-control types and constants for the pipelined MIPS core.
package mips_pkg;

    localparam int unsigned SEL_W   = 2;
    localparam int unsigned PC_STEP = 4;

    // Next-PC mux select encodings
    localparam logic [SEL_W-1:0] SEL_BRANCH = 2'b00;
    localparam logic [SEL_W-1:0] SEL_JUMP   = 2'b01;
    localparam logic [SEL_W-1:0] SEL_INCR   = 2'b10;

    // PC sequencer operating states
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STEP   = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the PC sequencer and its neighbours
// (hazard unit, debug unit, fetch-stage next-PC mux).
interface pc_sequencer_if
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  branch_taken;
    logic                  jump;
    logic                  stall;
    logic                  halt;
    logic                  debug_mode;
    logic                  step;
    logic                  restart;
    logic [DATA_WIDTH-1:0] pc_next;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_incr;
    logic [SEL_W-1:0]      pc_select;
    logic                  pc_write;
    logic                  flush;
    logic                  halted;
    logic [DATA_WIDTH-1:0] advance_count;

    // Sequencer side
    modport master (
        input  branch_taken, jump, stall, halt, debug_mode, step, restart, pc_next,
        output pc, pc_incr, pc_select, pc_write, flush, halted, advance_count
    );

    // Control / mux side
    modport slave (
        output branch_taken, jump, stall, halt, debug_mode, step, restart, pc_next,
        input  pc, pc_incr, pc_select, pc_write, flush, halted, advance_count
    );

endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: owns the PC register and incrementer, selects the
// next-PC mux input and gates PC updates by stall, halt and single-step mode.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_branch_taken,
    input  logic                  i_jump,
    input  logic                  i_stall,
    input  logic                  i_halt,
    input  logic                  i_debug_mode,
    input  logic                  i_step,
    input  logic                  i_restart,
    input  logic [DATA_WIDTH-1:0] i_pc_next,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic [DATA_WIDTH-1:0] o_pc_incr,
    output logic [SEL_W-1:0]      o_pc_select,
    output logic                  o_pc_write,
    output logic                  o_flush,
    output logic                  o_halted,
    output logic [DATA_WIDTH-1:0] o_advance_count
);

    seq_state_e            state_q, state_d;
    logic                  step_pending_q, step_pending_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic                  adv_c;

    // Next-PC select: the branch belongs to the older instruction, so it wins
    always_comb begin
        o_pc_select = SEL_INCR;
        if (i_branch_taken) begin
            o_pc_select = SEL_BRANCH;
        end else if (i_jump) begin
            o_pc_select = SEL_JUMP;
        end
    end

    // Advance qualifier, evaluated on the current state only
    always_comb begin
        adv_c = 1'b0;
        if (!i_halt && !i_stall) begin
            case (state_q)
                ST_RUN:  adv_c = 1'b1;
                ST_STEP: adv_c = i_step || step_pending_q;
                default: adv_c = 1'b0;
            endcase
        end
    end

    // Next state, step latch, PC and advance counter
    always_comb begin
        state_d        = state_q;
        step_pending_d = step_pending_q;
        pc_d           = pc_q;
        count_d        = count_q;

        if (adv_c) begin
            pc_d    = i_pc_next;
            count_d = count_q + DATA_WIDTH'(1);
        end

        case (state_q)
            ST_RUN: begin
                step_pending_d = 1'b0;
                if (i_halt) begin
                    state_d = ST_HALTED;
                end else if (i_debug_mode) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (i_halt) begin
                    state_d        = ST_HALTED;
                    step_pending_d = 1'b0;
                end else if (!i_debug_mode) begin
                    state_d        = ST_RUN;
                    step_pending_d = 1'b0;
                end else if (adv_c) begin
                    step_pending_d = 1'b0;
                end else if (i_step) begin
                    step_pending_d = 1'b1;
                end
            end
            ST_HALTED: begin
                if (i_restart) begin
                    state_d        = ST_RUN;
                    step_pending_d = 1'b0;
                    pc_d           = RESET_PC;
                end
            end
            default: begin
                state_d        = ST_RUN;
                step_pending_d = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q        <= ST_RUN;
            step_pending_q <= 1'b0;
            pc_q           <= RESET_PC;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            step_pending_q <= step_pending_d;
            pc_q           <= pc_d;
            count_q        <= count_d;
        end
    end

    assign o_pc            = pc_q;
    assign o_pc_incr       = pc_q + DATA_WIDTH'(PC_STEP);
    assign o_pc_write      = adv_c;
    assign o_flush         = adv_c && (i_branch_taken || i_jump);
    assign o_halted        = (state_q == ST_HALTED);
    assign o_advance_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized control traffic,
// checked every cycle against a behavioural model of the fetch controller.
module tb_pc_sequencer;
    import mips_pkg::*;

    localparam int unsigned     DW     = 32;
    localparam logic [DW-1:0]   RST_PC = 32'h0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.DATA_WIDTH(DW)) ifc ();

    logic [DW-1:0] btgt;
    logic [DW-1:0] jtgt;

    // Fetch-stage next-PC mux, driven by the DUT select and incrementer
    assign ifc.pc_next = (ifc.pc_select == SEL_BRANCH) ? btgt :
                         (ifc.pc_select == SEL_JUMP)   ? jtgt : ifc.pc_incr;

    pc_sequencer #(.DATA_WIDTH(DW), .RESET_PC(RST_PC)) dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_branch_taken  (ifc.branch_taken),
        .i_jump          (ifc.jump),
        .i_stall         (ifc.stall),
        .i_halt          (ifc.halt),
        .i_debug_mode    (ifc.debug_mode),
        .i_step          (ifc.step),
        .i_restart       (ifc.restart),
        .i_pc_next       (ifc.pc_next),
        .o_pc            (ifc.pc),
        .o_pc_incr       (ifc.pc_incr),
        .o_pc_select     (ifc.pc_select),
        .o_pc_write      (ifc.pc_write),
        .o_flush         (ifc.flush),
        .o_halted        (ifc.halted),
        .o_advance_count (ifc.advance_count)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: architectural PC, update count, mode flags
    logic [DW-1:0] m_pc;
    logic [DW-1:0] m_cnt;
    bit            m_halted;
    bit            m_stepmode;
    bit            m_pending;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc       = RST_PC;
        m_cnt      = '0;
        m_halted   = 1'b0;
        m_stepmode = 1'b0;
        m_pending  = 1'b0;
    endtask

    task automatic clear_in();
        ifc.branch_taken = 1'b0;
        ifc.jump         = 1'b0;
        ifc.stall        = 1'b0;
        ifc.halt         = 1'b0;
        ifc.debug_mode   = 1'b0;
        ifc.step         = 1'b0;
        ifc.restart      = 1'b0;
    endtask

    // Compare every output against the model, then move the model across the edge
    task automatic compare_and_advance();
        bit            adv;
        logic [1:0]    sel;
        logic [DW-1:0] nxt;
        adv = !m_halted && !ifc.halt && !ifc.stall &&
              (!m_stepmode || ifc.step || m_pending);
        sel = ifc.branch_taken ? 2'b00 : (ifc.jump ? 2'b01 : 2'b10);
        nxt = ifc.branch_taken ? btgt : (ifc.jump ? jtgt : m_pc + 32'd4);

        chk("pc",         ifc.pc,                 m_pc);
        chk("pc_incr",    ifc.pc_incr,            m_pc + 32'd4);
        chk("count",      ifc.advance_count,      m_cnt);
        chk("halted",     DW'(ifc.halted),        DW'(m_halted));
        chk("pc_select",  DW'(ifc.pc_select),     DW'(sel));
        chk("pc_write",   DW'(ifc.pc_write),      DW'(adv));
        chk("flush",      DW'(ifc.flush),         DW'(adv && (ifc.branch_taken || ifc.jump)));

        if (m_halted) begin
            if (ifc.restart) begin
                m_halted   = 1'b0;
                m_stepmode = 1'b0;
                m_pending  = 1'b0;
                m_pc       = RST_PC;
            end
        end else begin
            if (adv) begin
                m_pc  = nxt;
                m_cnt = m_cnt + 32'd1;
            end
            if (m_stepmode)
                m_pending = !ifc.halt && ifc.debug_mode && !adv && (m_pending || ifc.step);
            else
                m_pending = 1'b0;
            if (ifc.halt) m_halted = 1'b1;
            else          m_stepmode = ifc.debug_mode;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_and_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Async reset pulled while the clock is high, released just after an edge
    task automatic reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_reset_pc",     ifc.pc,            RST_PC);
        chk("mid_reset_count",  ifc.advance_count, 32'd0);
        chk("mid_reset_halted", DW'(ifc.halted),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        clear_in();
        btgt = '0;
        jtgt = '0;
        model_reset();

        // Reset values
        #12;
        chk("reset_pc",     ifc.pc,               32'h0);
        chk("reset_count",  ifc.advance_count,    32'd0);
        chk("reset_halted", DW'(ifc.halted),      32'd0);
        chk("reset_sel",    DW'(ifc.pc_select),   32'd2);
        chk("reset_incr",   ifc.pc_incr,          32'd4);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Free run: 0, 4, 8, 12
        ticks(3);
        chk("run_pc",    ifc.pc,            32'hC);
        chk("run_count", ifc.advance_count, 32'd3);

        // Branch and jump together: branch target wins
        ifc.branch_taken = 1'b1; ifc.jump = 1'b1;
        btgt = 32'h40; jtgt = 32'h80;
        #1;
        chk("bj_sel",   DW'(ifc.pc_select), 32'd0);
        chk("bj_flush", DW'(ifc.flush),     32'd1);
        tick();
        clear_in();
        chk("bj_pc", ifc.pc, 32'h40);

        // Stall for three cycles freezes PC and count
        ifc.stall = 1'b1;
        ticks(3);
        ifc.stall = 1'b0;
        chk("stall_pc",    ifc.pc,            32'h40);
        chk("stall_count", ifc.advance_count, 32'd4);
        tick();
        chk("unstall_pc", ifc.pc, 32'h44);

        // Single-step: mode takes effect the cycle after it is raised
        ifc.debug_mode = 1'b1;
        tick();
        ticks(5);
        chk("step_idle_pc", ifc.pc, 32'h48);
        ifc.step = 1'b1; ifc.stall = 1'b1;
        tick();
        ifc.step = 1'b0;
        tick();
        ifc.stall = 1'b0;
        tick();
        chk("step_once_pc", ifc.pc, 32'h4C);
        ticks(2);
        chk("step_no_repeat_pc", ifc.pc, 32'h4C);

        // Leave a step pending, then reset mid-cycle
        ifc.step = 1'b1; ifc.stall = 1'b1;
        tick();
        ifc.step = 1'b0; ifc.stall = 1'b0;
        reset_mid();
        ticks(3);
        chk("post_reset_pc", ifc.pc, 32'h4);
        ifc.debug_mode = 1'b0;
        ticks(12);
        chk("pre_halt_pc", ifc.pc, 32'h30);

        // Halt, ignore traffic, then restart
        ifc.halt = 1'b1;
        tick();
        ifc.halt = 1'b0;
        chk("halt_pc",     ifc.pc,          32'h30);
        chk("halt_flag",   DW'(ifc.halted), 32'd1);
        ifc.step = 1'b1; ifc.branch_taken = 1'b1; ifc.jump = 1'b1; btgt = 32'h100;
        ticks(3);
        clear_in();
        chk("halt_hold_pc", ifc.pc, 32'h30);
        ifc.restart = 1'b1;
        tick();
        ifc.restart = 1'b0;
        chk("restart_pc",     ifc.pc,          RST_PC);
        chk("restart_halted", DW'(ifc.halted), 32'd0);
        tick();
        chk("restart_adv_pc", ifc.pc, 32'h4);

        // Incrementer wrap at the top of the address space
        ifc.branch_taken = 1'b1; btgt = 32'hFFFF_FFFC;
        tick();
        clear_in();
        chk("wrap_incr", ifc.pc_incr, 32'h0);
        tick();
        chk("wrap_pc", ifc.pc, 32'h0);

        // Randomized control traffic
        for (int i = 0; i < 3000; i++) begin
            ifc.stall        = ($urandom_range(3) == 0);
            ifc.step         = ($urandom_range(2) == 0);
            ifc.branch_taken = ($urandom_range(7) == 0);
            ifc.jump         = ($urandom_range(7) == 0);
            ifc.halt         = ($urandom_range(39) == 0);
            ifc.restart      = ($urandom_range(3) == 0);
            if ($urandom_range(19) == 0) ifc.debug_mode = !ifc.debug_mode;
            btgt = $urandom() & 32'hFFFF_FFFC;
            jtgt = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(399) == 0) reset_mid();
            else                          tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
